// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// master = fetch_unit side, slave = pipeline/memory side.
interface fetch_unit_if #(
   parameter int PC_W   = 4,
   parameter int INST_W = 16
);
   logic              stall;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_data;
   logic [PC_W-1:0]   pcadd4;
   logic [INST_W-1:0] inst;
   logic              fetch_valid;
   logic              halted;
   logic [15:0]       inst_count;
   logic [1:0]        fsm_state;

   // fetch_valid qualifies inst for one cycle; stall holds the same inst
   // valid on the next cycle; redirect squashes the current inst.
   modport master (
      input  stall, redirect, redirect_pc, imem_data,
      output imem_addr, pcadd4, inst, fetch_valid, halted, inst_count, fsm_state
   );

   modport slave (
      output stall, redirect, redirect_pc, imem_data,
      input  imem_addr, pcadd4, inst, fetch_valid, halted, inst_count, fsm_state
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, applies stall/redirect, stops after HALT.
// Optional delivered-instruction counter enabled by macro FETCH_INST_CNT_EN.
module fetch_unit #(
   parameter int              PC_W     = 4,
   parameter int              INST_W   = 16,
   parameter int              PC_INC   = 1,
   parameter int              RESET_PC = 0,
   parameter logic [3:0]      HALT_OP  = 4'hF,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input logic             clk,
   input logic             rst_n,
   fetch_unit_if.master    bus
);
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [PC_W-1:0] INC   = PC_W'(PC_INC);
   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

   state_t          state, state_next;
   logic [PC_W-1:0] pc, pc_next;
   logic            valid;
   logic            is_halt;

   assign is_halt = (bus.imem_data[INST_W-1 -: 4] == HALT_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
         pc    <= RST_PC;
      end else begin
         state <= state_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      valid      = 1'b0;
      case (state)
         BOOT: begin
            state_next = RUN;
            if (bus.redirect) pc_next = bus.redirect_pc;
         end
         RUN: begin
            // redirect outranks stall: the fetched word is wrong-path
            if (bus.redirect) begin
               pc_next = bus.redirect_pc;
            end else if (bus.stall) begin
               valid = 1'b1;
            end else if (is_halt) begin
               valid      = 1'b1;
               pc_next    = pc + INC;
               state_next = HALTED;
            end else begin
               valid   = 1'b1;
               pc_next = pc + INC;
            end
         end
         HALTED: begin
            if (bus.redirect) begin
               pc_next    = bus.redirect_pc;
               state_next = RUN;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   assign bus.imem_addr   = pc;
   assign bus.pcadd4      = pc + INC;
   assign bus.fetch_valid = valid;
   assign bus.inst        = valid ? bus.imem_data : NOP_INST;
   assign bus.halted      = (state == HALTED);
   assign bus.fsm_state   = state;

`ifdef FETCH_INST_CNT_EN
   logic [15:0] cnt;
   logic        handed;

   assign handed = valid && !bus.stall && !bus.redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        cnt <= 16'h0000;
      else if (handed && cnt != 16'hFFFF) cnt <= cnt + 16'h0001;
   end

   assign bus.inst_count = cnt;
`else
   assign bus.inst_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/redirect
// traffic, compared against a per-cycle behavioural model of the fetch stage.
module tb_fetch_unit;
   logic clk;
   logic rst_n;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] mem [16];
   assign bus.imem_data = mem[bus.imem_addr];

   int total = 0;
   int bad   = 0;

   // model state: next-fetch address, boot bubble pending, halted, handed-on count
   int m_pc;
   bit m_boot;
   bit m_halt;
   int m_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc   = 0;
      m_boot = 1;
      m_halt = 0;
      m_cnt  = 0;
   endtask

   task automatic fill_linear();
      for (int a = 0; a < 16; a++) mem[a] = 16'h1000 + 16'(a);
   endtask

   // Called at a falling edge: drive inputs, check outputs, advance the model,
   // then wait for the next falling edge.
   task automatic step(input bit st, input bit rd, input int rpc);
      logic [15:0] exp_inst;
      bit          exp_valid;
      logic [15:0] word;
      bus.stall       = st;
      bus.redirect    = rd;
      bus.redirect_pc = 4'(rpc);
      #1;
      word      = mem[m_pc];
      exp_valid = !m_boot && !m_halt && !rd;
      exp_inst  = exp_valid ? word : 16'h0000;
      check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
      check("pcadd4",      32'(bus.pcadd4),      32'((m_pc + 1) % 16));
      check("fetch_valid", 32'(bus.fetch_valid), 32'(exp_valid));
      check("inst",        32'(bus.inst),        32'(exp_inst));
      check("halted",      32'(bus.halted),      32'(m_halt));
`ifdef FETCH_INST_CNT_EN
      check("inst_count",  32'(bus.inst_count),  32'(m_cnt));
`else
      check("inst_count",  32'(bus.inst_count),  32'h0);
`endif
      if (rd) begin
         m_pc   = rpc % 16;
         m_boot = 0;
         m_halt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (!m_halt && !st) begin
         if (m_cnt < 65535) m_cnt++;
         if (word[15:12] == 4'hF) m_halt = 1;
         m_pc = (m_pc + 1) % 16;
      end
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_addr"},   32'(bus.imem_addr),   32'h0);
      check({tag, "_pcadd4"}, 32'(bus.pcadd4),      32'h1);
      check({tag, "_inst"},   32'(bus.inst),        32'h0);
      check({tag, "_valid"},  32'(bus.fetch_valid), 32'h0);
      check({tag, "_halted"}, 32'(bus.halted),      32'h0);
      check({tag, "_count"},  32'(bus.inst_count),  32'h0);
   endtask

   initial begin
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      fill_linear();
      rst_n = 1'b0;
      model_reset();
      #3;
      check_reset_values("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // boot bubble, 16 sequential fetches with wrap, then advance to pc=3
      for (int i = 0; i < 20; i++) step(0, 0, 0);
      // stall three cycles at pc=3, then sequential to pc=5
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      // redirect with simultaneous stall at pc=5
      step(1, 1, 10);
      step(0, 0, 0);
      // HALT at pc=6, frozen for 10 cycles with random stall, then redirect to 2
      mem[6] = 16'hF000;
      step(0, 1, 6);
      step(0, 0, 0);
      for (int i = 0; i < 10; i++) step(bit'($urandom_range(0, 1)), 0, 0);
      step(0, 1, 2);
      mem[6] = 16'h1006;
      // advance to pc=9, redirect to the current pc, then stall there
      for (int i = 0; i < 7; i++) step(0, 0, 0);
      step(0, 1, 9);
      step(1, 0, 0);
      // asynchronous reset mid-stall, no clock edge before the check
      bus.stall = 1'b1;
      #1;
      rst_n = 1'b0;
      #2;
      check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.stall = 1'b0;
      for (int i = 0; i < 4; i++) step(0, 0, 0);

      // counter scenario: 8 fetches interleaved with 2 stalls and 1 redirect
      step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(0, 1, 12); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

      // random traffic with sprinkled HALTs
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 16; a++)
            mem[a] = ($urandom_range(0, 7) == 0) ? (16'hF000 | 16'($urandom_range(0, 4095)))
                                                 : 16'($urandom_range(0, 16'hEFFF));
         for (int i = 0; i < 150; i++)
            step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
